// File: rtl/clk_div_bank.sv
// clk_div_bank: a bank of independent, runtime-programmable clock dividers.
// Each channel owns an active divisor and a one-deep pending divisor slot.
// A new divisor is taken in only at a period boundary, so the divided clock
// never glitches. Each channel drives a registered ~50% duty clock and a
// one-cycle tick that marks every rising edge of that clock.
module clk_div_bank #(
    parameter int unsigned NumChannels = 2,
    parameter int unsigned CntWidth    = 16,
    parameter int unsigned DefaultDiv  = 50
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumChannels-1:0]          en_i,
    input  logic [NumChannels*CntWidth-1:0] div_i,
    input  logic [NumChannels-1:0]          div_valid_i,
    output logic [NumChannels-1:0]          div_ready_o,
    output logic [NumChannels-1:0]          clk_o,
    output logic [NumChannels-1:0]          tick_o
);

    localparam logic [CntWidth-1:0] DefDivC = CntWidth'(DefaultDiv);
    localparam logic [CntWidth-1:0] ZeroC   = CntWidth'(0);
    localparam logic [CntWidth-1:0] OneC    = CntWidth'(1);
    localparam logic [CntWidth:0]   OneWC   = (CntWidth + 1)'(1);

    for (genvar c = 0; c < NumChannels; c++) begin : g_ch

        // Channel state
        logic [CntWidth-1:0] r_div;
        logic [CntWidth-1:0] r_pend;
        logic                r_pend_vld;
        logic [CntWidth-1:0] r_cnt;
        logic                r_run;
        logic                r_clk;
        logic                r_tick;

        // Next-state values
        logic [CntWidth-1:0] w_div_req;
        logic                w_accept;
        logic                w_apply;
        logic                w_wrap;
        logic                w_out_on;
        logic [CntWidth-1:0] w_div_eff;
        logic [CntWidth-1:0] w_cnt_d;
        logic                w_run_d;
        logic [CntWidth-1:0] w_pend_d;
        logic                w_pend_vld_d;
        logic [CntWidth:0]   w_half;
        logic                w_clk_d;
        logic                w_tick_d;

        assign w_div_req = div_i[c*CntWidth +: CntWidth];
        assign w_accept  = div_valid_i[c] & ~r_pend_vld;

        // Channel sequencing: idle / start / run, with divisor apply at period boundaries
        always_comb begin
            w_wrap   = 1'b0;
            w_apply  = 1'b0;
            w_out_on = 1'b0;
            w_cnt_d  = r_cnt;
            w_run_d  = r_run;
            if (!en_i[c]) begin
                // Idle: everything parked, a pending divisor lands right away
                w_run_d  = 1'b0;
                w_cnt_d  = ZeroC;
                w_apply  = r_pend_vld;
                w_out_on = 1'b0;
            end else if (!r_run) begin
                // Start: begin a fresh period at count 0 with the newest divisor
                w_run_d  = 1'b1;
                w_cnt_d  = ZeroC;
                w_apply  = r_pend_vld;
                w_out_on = 1'b1;
            end else if (r_div == ZeroC) begin
                // Stalled on a zero divisor; a pending divisor acts as a wrap
                w_run_d = 1'b1;
                if (r_pend_vld) begin
                    w_wrap   = 1'b1;
                    w_apply  = 1'b1;
                    w_cnt_d  = ZeroC;
                    w_out_on = 1'b1;
                end else begin
                    w_wrap   = 1'b0;
                    w_apply  = 1'b0;
                    w_cnt_d  = r_cnt;
                    w_out_on = 1'b0;
                end
            end else begin
                // Running: count up to D-1, then wrap and maybe take the new divisor
                w_run_d  = 1'b1;
                w_wrap   = (r_cnt == (r_div - OneC));
                w_apply  = w_wrap & r_pend_vld;
                w_out_on = 1'b1;
                if (w_wrap) begin
                    w_cnt_d = ZeroC;
                end else begin
                    w_cnt_d = r_cnt + OneC;
                end
            end
            w_div_eff = w_apply ? r_pend : r_div;
        end

        // Pending-slot bookkeeping: capture on handshake, free on apply
        always_comb begin
            w_pend_d     = r_pend;
            w_pend_vld_d = r_pend_vld;
            if (w_apply) begin
                w_pend_vld_d = 1'b0;
            end else if (w_accept) begin
                w_pend_d     = w_div_req;
                w_pend_vld_d = 1'b1;
            end else begin
                w_pend_vld_d = r_pend_vld;
            end
        end

        // Output decode from the effective divisor and the next count
        always_comb begin
            // Half period rounded up; extra bit keeps D = 2^CntWidth-1 from overflowing
            w_half   = ({1'b0, w_div_eff} + OneWC) >> 1;
            w_clk_d  = 1'b0;
            w_tick_d = 1'b0;
            if (!w_out_on) begin
                w_clk_d  = 1'b0;
                w_tick_d = 1'b0;
            end else if (w_div_eff == ZeroC) begin
                w_clk_d  = 1'b0;
                w_tick_d = 1'b0;
            end else if (w_div_eff == OneC) begin
                w_clk_d  = 1'b1;
                w_tick_d = 1'b1;
            end else begin
                w_clk_d  = ({1'b0, w_cnt_d} < w_half);
                w_tick_d = (w_cnt_d == ZeroC);
            end
        end

        // Channel registers with synchronous reset
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_div      <= DefDivC;
                r_pend     <= ZeroC;
                r_pend_vld <= 1'b0;
                r_cnt      <= ZeroC;
                r_run      <= 1'b0;
                r_clk      <= 1'b0;
                r_tick     <= 1'b0;
            end else begin
                r_div      <= w_div_eff;
                r_pend     <= w_pend_d;
                r_pend_vld <= w_pend_vld_d;
                r_cnt      <= w_cnt_d;
                r_run      <= w_run_d;
                r_clk      <= w_clk_d;
                r_tick     <= w_tick_d;
            end
        end

        assign div_ready_o[c] = ~r_pend_vld;
        assign clk_o[c]       = r_clk;
        assign tick_o[c]      = r_tick;
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: per-cycle reference model comparison,
// a table of divisor scenarios, directed corner sequences and random traffic.
module tb_clk_div_bank;

    localparam int NC = 2;
    localparam int CW = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC-1:0]    en;
    logic [NC*CW-1:0] div;
    logic [NC-1:0]    valid;
    logic [NC-1:0]    ready;
    logic [NC-1:0]    clk_out;
    logic [NC-1:0]    tick;

    clk_div_bank #(.NumChannels(NC), .CntWidth(CW), .DefaultDiv(50)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .en_i        (en),
        .div_i       (div),
        .div_valid_i (valid),
        .div_ready_o (ready),
        .clk_o       (clk_out),
        .tick_o      (tick)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: each channel is a position inside a period of length D
    int m_div [NC];
    int m_pend[NC];
    bit m_pv  [NC];
    bit m_run [NC];
    int m_pos [NC];
    bit m_clk [NC];
    bit m_tick[NC];

    typedef struct {
        int div;
        int ncyc;
        int exp_high;
        int exp_ticks;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void mout(input int d, input int n, output bit c, output bit t);
        if (d == 0) begin
            c = 1'b0;
            t = 1'b0;
        end else begin
            c = (n < (d + 1) / 2);
            t = (n == 0);
        end
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            m_div[c] = 50; m_pend[c] = 0; m_pv[c] = 1'b0; m_run[c] = 1'b0;
            m_pos[c] = 0;  m_clk[c] = 1'b0; m_tick[c] = 1'b0;
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            int req;
            bit acc;
            req = int'(div[c*CW +: CW]);
            acc = valid[c] && !m_pv[c];
            if (rst) begin
                m_div[c] = 50; m_pend[c] = 0; m_pv[c] = 1'b0; m_run[c] = 1'b0;
                m_pos[c] = 0;  m_clk[c] = 1'b0; m_tick[c] = 1'b0;
            end else begin
                if (!en[c]) begin
                    m_run[c] = 1'b0; m_pos[c] = 0;
                    if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 1'b0; end
                    m_clk[c] = 1'b0; m_tick[c] = 1'b0;
                end else if (!m_run[c]) begin
                    m_run[c] = 1'b1; m_pos[c] = 0;
                    if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 1'b0; end
                    mout(m_div[c], 0, m_clk[c], m_tick[c]);
                end else if (m_div[c] == 0) begin
                    if (m_pv[c]) begin
                        m_div[c] = m_pend[c]; m_pv[c] = 1'b0; m_pos[c] = 0;
                        mout(m_div[c], 0, m_clk[c], m_tick[c]);
                    end else begin
                        m_clk[c] = 1'b0; m_tick[c] = 1'b0;
                    end
                end else begin
                    if (m_pos[c] == m_div[c] - 1) begin
                        m_pos[c] = 0;
                        if (m_pv[c]) begin m_div[c] = m_pend[c]; m_pv[c] = 1'b0; end
                    end else begin
                        m_pos[c] = m_pos[c] + 1;
                    end
                    mout(m_div[c], m_pos[c], m_clk[c], m_tick[c]);
                end
                if (acc) begin m_pend[c] = req; m_pv[c] = 1'b1; end
            end
        end
    endtask

    // One clock: advance the model at the edge, compare all outputs 1 ns later
    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        for (int c = 0; c < NC; c++) begin
            check($sformatf("model_clk_o[%0d]", c),  32'(clk_out[c]), 32'(m_clk[c]));
            check($sformatf("model_tick_o[%0d]", c), 32'(tick[c]),    32'(m_tick[c]));
            check($sformatf("model_ready[%0d]", c),  32'(ready[c]),   32'(!m_pv[c]));
        end
    endtask

    initial begin
        int hi;
        int tk;
        logic [9:0] exp_seq;
        logic [9:0] rdy_seq;

        tbl[0] = '{50,    100,   50,    2};
        tbl[1] = '{3,     9,     6,     3};
        tbl[2] = '{1,     5,     5,     5};
        tbl[3] = '{0,     5,     0,     0};
        tbl[4] = '{7,     14,    8,     2};
        tbl[5] = '{2,     6,     3,     3};
        tbl[6] = '{4,     8,     4,     2};
        tbl[7] = '{65535, 65535, 32768, 1};

        model_reset();
        rst = 1'b1; en = '0; valid = '0; div = '0;
        #1;
        step();
        step();
        check("reset_ready", 32'(ready),   32'(2'b11));
        check("reset_clk",   32'(clk_out), 32'(2'b00));
        check("reset_tick",  32'(tick),    32'(2'b00));
        rst = 1'b0;

        // Default divisor straight out of reset
        en = 2'b01;
        step();
        check("default_first_tick", 32'(tick[0]), 32'd1);
        hi = int'(clk_out[0]); tk = int'(tick[0]);
        repeat (49) begin step(); hi += int'(clk_out[0]); tk += int'(tick[0]); end
        check("default_high", 32'(hi), 32'd25);
        check("default_ticks", 32'(tk), 32'd1);
        step();
        check("default_next_tick", 32'(tick[0]), 32'd1);
        en = '0;
        step();

        // Table of divisors: load while idle, enable, count highs and ticks
        for (int i = 0; i < 8; i++) begin
            en = '0;
            div[CW-1:0] = CW'(tbl[i].div);
            valid[0] = 1'b1;
            step();
            valid[0] = 1'b0;
            step();
            step();
            en[0] = 1'b1;
            step();
            check($sformatf("tbl%0d_first_tick", i), 32'(tick[0]), 32'(tbl[i].div != 0));
            hi = int'(clk_out[0]); tk = int'(tick[0]);
            for (int k = 1; k < tbl[i].ncyc; k++) begin
                step();
                hi += int'(clk_out[0]); tk += int'(tick[0]);
            end
            check($sformatf("tbl%0d_high", i),  32'(hi), 32'(tbl[i].exp_high));
            check($sformatf("tbl%0d_ticks", i), 32'(tk), 32'(tbl[i].exp_ticks));
        end

        // Glitch-free update: D=10 running, D=4 requested at count 3, D=6 retried while pending
        en = '0;
        div[CW-1:0] = 16'd10; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        step();
        en[0] = 1'b1;
        step();
        repeat (3) step();
        div[CW-1:0] = 16'd4; valid[0] = 1'b1;
        exp_seq = 10'b0011000001;
        rdy_seq = 10'b1111000000;
        for (int i = 0; i < 10; i++) begin
            if (i == 1) div[CW-1:0] = 16'd6;
            if (i == 3) valid[0] = 1'b0;
            step();
            check($sformatf("glitch_clk%0d", i),   32'(clk_out[0]), 32'(exp_seq[i]));
            check($sformatf("glitch_ready%0d", i), 32'(ready[0]),   32'(rdy_seq[i]));
        end

        // Update while idle: ready low one cycle, back high the next; then D=3 pattern
        en = '0;
        step();
        div[CW-1:0] = 16'd3; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        check("idle_ready_low", 32'(ready[0]), 32'd0);
        step();
        check("idle_ready_high", 32'(ready[0]), 32'd1);
        en[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("div3_clk%0d", i), 32'(clk_out[0]), 32'((i % 3) != 2));
        end

        // Independence: ch0 D=50, ch1 D=7, disable ch1 mid-period then re-enable
        en = '0;
        div = {16'd7, 16'd50}; valid = 2'b11;
        step();
        valid = '0;
        step();
        en = 2'b11;
        step();
        repeat (3) step();
        check("ch1_high_before_drop", 32'(clk_out[1]), 32'd1);
        en[1] = 1'b0;
        step();
        check("ch1_drop_clk", 32'(clk_out[1]), 32'd0);
        check("ch0_unaffected", 32'(clk_out[0]), 32'd1);
        step();
        en[1] = 1'b1;
        step();
        check("ch1_reenable_tick", 32'(tick[1]), 32'd1);

        // Reset with a pending update: divisor returns to 50
        en = 2'b01;
        div[CW-1:0] = 16'd9; valid[0] = 1'b1;
        step();
        valid[0] = 1'b0;
        check("pend_before_rst", 32'(ready[0]), 32'd0);
        rst = 1'b1;
        step();
        check("rst_mid_clk",   32'(clk_out), 32'(2'b00));
        check("rst_mid_tick",  32'(tick),    32'(2'b00));
        check("rst_mid_ready", 32'(ready),   32'(2'b11));
        rst = 1'b0;
        step();
        hi = int'(clk_out[0]); tk = int'(tick[0]);
        repeat (49) begin step(); hi += int'(clk_out[0]); tk += int'(tick[0]); end
        check("post_rst_high",  32'(hi), 32'd25);
        check("post_rst_ticks", 32'(tk), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 29) == 0) en[c] = ~en[c];
                valid[c] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0)
                    div[c*CW +: CW] = CW'($urandom_range(0, 1));
                else
                    div[c*CW +: CW] = CW'($urandom_range(2, 12));
            end
            step();
        end
        rst = 1'b0; valid = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
